// File: rtl/reg_xfer_seq.sv
// Register-transfer micro-sequencer: decodes one command into 1 or 3 control steps.
// Optional build macro SEQ_REPEAT_EN repeats the step sequence cmd_cnt+1 times.
module reg_xfer_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_alu,
  input  logic [3:0] cmd_cnt,
  output logic       cmd_ready,
  output logic       xfer,
  output logic [1:0] src_sel,
  output logic [1:0] alu_op,
  output logic [1:0] as_ctrl,
  output logic [2:0] load,
  output logic       busy,
  output logic       done
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned ALU_W  = 2;
  localparam int unsigned STEP_W = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [OP_W-1:0] OP_INC_A   = 3'b001;
  localparam logic [OP_W-1:0] OP_DEC_B   = 3'b010;
  localparam logic [OP_W-1:0] OP_ALU_C   = 3'b011;
  localparam logic [OP_W-1:0] OP_MOV_AB  = 3'b100;
  localparam logic [OP_W-1:0] OP_MOV_BA  = 3'b101;
  localparam logic [OP_W-1:0] OP_SWAP_AB = 3'b110;
  localparam logic [OP_W-1:0] OP_CLR_ALL = 3'b111;

  logic [1:0]        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ALU_W-1:0]  alu_q, alu_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_step;
  logic              repeat_more;

`ifdef SEQ_REPEAT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  assign repeat_more = (rep_q != cnt_q);
`else
  logic unused_cnt;
  assign unused_cnt  = ^cmd_cnt;
  assign repeat_more = 1'b0;
`endif

  // SWAP is the only three-step opcode
  assign last_step = (op_q == OP_SWAP_AB) ? STEP_W'(2) : STEP_W'(0);

  // Next-state logic and combinational step decode
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    alu_d     = alu_q;
    step_d    = step_q;
`ifdef SEQ_REPEAT_EN
    cnt_d     = cnt_q;
    rep_d     = rep_q;
`endif
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    xfer      = 1'b0;
    src_sel   = 2'b00;
    alu_op    = 2'b00;
    as_ctrl   = 2'b00;
    load      = 3'b000;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          alu_d   = cmd_alu;
          step_d  = STEP_W'(0);
`ifdef SEQ_REPEAT_EN
          cnt_d   = cmd_cnt;
          rep_d   = CNT_W'(0);
`endif
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        busy = 1'b1;
        case (op_q)
          OP_INC_A:  load = 3'b001;
          OP_DEC_B: begin
            as_ctrl = 2'b10;
            load    = 3'b010;
          end
          OP_ALU_C: begin
            alu_op = alu_q;
            load   = 3'b100;
          end
          OP_MOV_AB: begin
            xfer = 1'b1;
            load = 3'b010;
          end
          OP_MOV_BA: begin
            xfer    = 1'b1;
            src_sel = 2'b01;
            load    = 3'b001;
          end
          OP_SWAP_AB: begin
            xfer = 1'b1;
            case (step_q)
              STEP_W'(0): begin
                src_sel = 2'b00;
                load    = 3'b100;
              end
              STEP_W'(1): begin
                src_sel = 2'b01;
                load    = 3'b001;
              end
              default: begin
                src_sel = 2'b10;
                load    = 3'b010;
              end
            endcase
          end
          OP_CLR_ALL: begin
            xfer    = 1'b1;
            src_sel = 2'b11;
            load    = 3'b111;
          end
          default: ;
        endcase

        // End of a pass: either restart for another repeat or finish
        if (step_q == last_step) begin
          step_d = STEP_W'(0);
          if (repeat_more) begin
`ifdef SEQ_REPEAT_EN
            rep_d = rep_q + CNT_W'(1);
`endif
          end else begin
            state_d = S_DONE;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      alu_q   <= '0;
      step_q  <= '0;
`ifdef SEQ_REPEAT_EN
      cnt_q   <= '0;
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      step_q  <= step_d;
`ifdef SEQ_REPEAT_EN
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
`endif
    end
  end

endmodule
